// File: rtl/eth_speed_pkg.sv
// Shared Ethernet speed definitions for the PHY status, MAC and RGMII TX
// clock control blocks.
//   speed_e        : two-bit link speed code as reported by the PHY
//   ctrl_state_e   : sequencing states of rgmii_tx_speed_ctrl
//   max_u()        : elaboration-time helper for sizing shared counters
package eth_speed_pkg;

   typedef enum logic [1:0] {
      SPEED_10M     = 2'b00,
      SPEED_100M    = 2'b01,
      SPEED_1000M   = 2'b10,
      SPEED_INVALID = 2'b11
   } speed_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_DRAIN  = 2'b01,
      ST_RESET  = 2'b10,
      ST_SETTLE = 2'b11
   } ctrl_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/eth_cycle_timer.sv
// Cycle timer shared by the DRAIN, RESET and SETTLE phases of the speed
// controller. Counts clock cycles since the last clear; done is high on the
// last cycle of a window that is `limit` cycles long.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   clear  in   restart the window (count returns to 0)
//   limit  in   window length in cycles (>= 1)
//   done   out  high while count == limit-1
module eth_cycle_timer #(
   parameter int unsigned width_p = 13
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic [width_p-1:0] limit,
   output logic               done
);

   logic [width_p-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else begin
         count <= count + width_p'(1);
      end
   end

   // The owning state leaves on done, so count never runs past limit-1.
   assign done = (count == limit - width_p'(1));

endmodule

// File: rtl/rgmii_tx_speed_ctrl.sv
// Link-speed change sequencer for the RGMII TX clock generator (clk250 domain).
// Debounces the PHY-reported speed, holds off the MAC TX path, keeps the
// clock/gtx generator in reset while its setting changes, then releases it
// and reopens TX after a settle window.
//   clk250_i         in   250 MHz clock
//   clk250_rst_ni    in   asynchronous active-low reset
//   phy_speed_i      in   PHY speed level (2'b11 = invalid)
//   tx_busy_i        in   MAC frame in progress
//   tx_hold_o        out  MAC must not start a new frame
//   gen_reset_o      out  active-high generator reset
//   clk_setting_o    out  generator clock setting (= committed speed)
//   speed_o          out  committed speed
//   change_done_o    out  one-cycle pulse when a change / bring-up completes
//   drain_timeout_o  out  one-cycle pulse when a drain was forced
module rgmii_tx_speed_ctrl
   import eth_speed_pkg::*;
#(
   parameter logic [1:0]  init_speed_p       = 2'b10,
   parameter int unsigned debounce_cycles_p  = 16,
   parameter int unsigned drain_timeout_p    = 4096,
   parameter int unsigned gen_reset_cycles_p = 8,
   parameter int unsigned settle_cycles_p    = 32
) (
   input  logic       clk250_i,
   input  logic       clk250_rst_ni,
   input  logic [1:0] phy_speed_i,
   input  logic       tx_busy_i,
   output logic       tx_hold_o,
   output logic       gen_reset_o,
   output logic [1:0] clk_setting_o,
   output logic [1:0] speed_o,
   output logic       change_done_o,
   output logic       drain_timeout_o
);

   localparam int unsigned cyc_max_c = max_u(max_u(debounce_cycles_p, drain_timeout_p),
                                             max_u(gen_reset_cycles_p, settle_cycles_p));
   localparam int unsigned tmr_w_c   = $clog2(cyc_max_c + 1);
   localparam int unsigned deb_w_c   = $clog2(debounce_cycles_p + 1);

   ctrl_state_e        state, state_nxt;
   logic [1:0]         target, target_nxt;
   logic [1:0]         speed, speed_nxt;
   logic [1:0]         prev_sample;
   logic [deb_w_c-1:0] deb_cnt, deb_nxt;
   logic               hold_nxt, gen_nxt, done_nxt, tmo_nxt;
   logic [tmr_w_c-1:0] tmr_limit;
   logic               tmr_clear, tmr_done;

   always_comb begin
      tmr_limit = '0;
      case (state)
         ST_DRAIN:  tmr_limit = tmr_w_c'(drain_timeout_p);
         ST_RESET:  tmr_limit = tmr_w_c'(gen_reset_cycles_p);
         ST_SETTLE: tmr_limit = tmr_w_c'(settle_cycles_p);
         default:   tmr_limit = '0;
      endcase
   end

   // Every phase starts its window from zero; the timer is idle in IDLE.
   assign tmr_clear = (state_nxt != state) || (state == ST_IDLE);

   eth_cycle_timer #(
      .width_p (tmr_w_c)
   ) u_timer (
      .clk   (clk250_i),
      .rst_n (clk250_rst_ni),
      .clear (tmr_clear),
      .limit (tmr_limit),
      .done  (tmr_done)
   );

   always_comb begin
      state_nxt  = state;
      target_nxt = target;
      speed_nxt  = speed;
      deb_nxt    = '0;
      hold_nxt   = tx_hold_o;
      gen_nxt    = gen_reset_o;
      done_nxt   = 1'b0;
      tmo_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            hold_nxt = 1'b0;
            gen_nxt  = 1'b0;
            if ((phy_speed_i != speed) && (phy_speed_i != SPEED_INVALID)) begin
               // A fresh value (or the first one after a clear) restarts at 1.
               deb_nxt = (phy_speed_i == prev_sample) ? deb_cnt + deb_w_c'(1) : deb_w_c'(1);
               if (deb_nxt == deb_w_c'(debounce_cycles_p)) begin
                  state_nxt  = ST_DRAIN;
                  target_nxt = phy_speed_i;
                  hold_nxt   = 1'b1;
                  deb_nxt    = '0;
               end
            end
         end
         ST_DRAIN: begin
            hold_nxt = 1'b1;
            if (!tx_busy_i || tmr_done) begin
               // Setting moves together with the generator entering reset.
               tmo_nxt   = tx_busy_i;
               state_nxt = ST_RESET;
               gen_nxt   = 1'b1;
               speed_nxt = target;
            end
         end
         ST_RESET: begin
            if (tmr_done) begin
               state_nxt = ST_SETTLE;
               gen_nxt   = 1'b0;
            end
         end
         ST_SETTLE: begin
            if (tmr_done) begin
               state_nxt = ST_IDLE;
               hold_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_RESET;
      endcase
   end

   always_ff @(posedge clk250_i or negedge clk250_rst_ni) begin
      if (!clk250_rst_ni) begin
         state           <= ST_RESET;
         target          <= init_speed_p;
         speed           <= init_speed_p;
         prev_sample     <= init_speed_p;
         deb_cnt         <= '0;
         tx_hold_o       <= 1'b1;
         gen_reset_o     <= 1'b1;
         change_done_o   <= 1'b0;
         drain_timeout_o <= 1'b0;
      end else begin
         state           <= state_nxt;
         target          <= target_nxt;
         speed           <= speed_nxt;
         prev_sample     <= phy_speed_i;
         deb_cnt         <= deb_nxt;
         tx_hold_o       <= hold_nxt;
         gen_reset_o     <= gen_nxt;
         change_done_o   <= done_nxt;
         drain_timeout_o <= tmo_nxt;
      end
   end

   assign speed_o       = speed;
   assign clk_setting_o = speed;

endmodule

// File: tb/tb_rgmii_tx_speed_ctrl.sv
// Bench for rgmii_tx_speed_ctrl: directed stimulus, a sequential behavioural
// model compared every cycle, and literal expectations at key cycles.
module tb_rgmii_tx_speed_ctrl;

   localparam logic [1:0] INIT     = 2'b10;
   localparam int         DEB      = 16;
   localparam int         DRAIN_TO = 4096;
   localparam int         GEN      = 8;
   localparam int         SETTLE   = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] phy_speed = 2'b10;
   logic       tx_busy = 1'b0;
   logic       tx_hold, gen_reset, change_done, drain_timeout;
   logic [1:0] clk_setting, speed;

   int checks = 0;
   int errors = 0;

   rgmii_tx_speed_ctrl #(
      .init_speed_p       (INIT),
      .debounce_cycles_p  (DEB),
      .drain_timeout_p    (DRAIN_TO),
      .gen_reset_cycles_p (GEN),
      .settle_cycles_p    (SETTLE)
   ) dut (
      .clk250_i        (clk),
      .clk250_rst_ni   (rst_n),
      .phy_speed_i     (phy_speed),
      .tx_busy_i       (tx_busy),
      .tx_hold_o       (tx_hold),
      .gen_reset_o     (gen_reset),
      .clk_setting_o   (clk_setting),
      .speed_o         (speed),
      .change_done_o   (change_done),
      .drain_timeout_o (drain_timeout)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic       m_hold, m_gen, m_done, m_tmo;
   logic [1:0] m_speed;

   task automatic step();
      @(posedge clk);
      m_done = 1'b0;
      m_tmo  = 1'b0;
   endtask

   task automatic model_body();
      logic [1:0] tgt, s, old;
      logic [1:0] hist[$];
      int         n;
      bit         go;
      tgt = INIT;
      forever begin
         m_speed = tgt;
         repeat (GEN) step();
         m_gen = 1'b0;
         repeat (SETTLE) step();
         m_hold = 1'b0;
         m_done = 1'b1;
         // idle: change once the last DEB samples are one valid new speed
         hist.delete();
         go = 0;
         s  = 2'b00;
         while (!go) begin
            step();
            s = phy_speed;
            hist.push_back(s);
            if (hist.size() > DEB) old = hist.pop_front();
            go = (hist.size() == DEB) && (s != m_speed) && (s != 2'b11);
            foreach (hist[i]) if (hist[i] != s) go = 0;
         end
         tgt    = s;
         m_hold = 1'b1;
         n      = 0;
         forever begin
            step();
            if (!tx_busy) break;
            n++;
            if (n == DRAIN_TO) begin
               m_tmo = 1'b1;
               break;
            end
         end
         m_gen = 1'b1;
      end
   endtask

   always begin
      m_hold  = 1'b1;
      m_gen   = 1'b1;
      m_speed = INIT;
      m_done  = 1'b0;
      m_tmo   = 1'b0;
      wait (rst_n === 1'b1);
      fork
         model_body();
         @(negedge rst_n);
      join_any
      disable fork;
   end

   // ---------------- checking helpers ----------------
   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic lit(input string tag, input logic h, input logic g, input logic [1:0] sp,
                      input logic d, input logic t);
      chk1({tag, "_hold"}, tx_hold, h);
      chk1({tag, "_gen"}, gen_reset, g);
      chk2({tag, "_speed"}, speed, sp);
      chk2({tag, "_setting"}, clk_setting, sp);
      chk1({tag, "_done"}, change_done, d);
      chk1({tag, "_tmo"}, drain_timeout, t);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus + compare ----------------
   initial begin
      logic saw;
      fork
         forever begin
            @(negedge clk);
            chk1("cmp_hold", tx_hold, m_hold);
            chk1("cmp_gen", gen_reset, m_gen);
            chk2("cmp_speed", speed, m_speed);
            chk2("cmp_setting", clk_setting, m_speed);
            chk1("cmp_done", change_done, m_done);
            chk1("cmp_tmo", drain_timeout, m_tmo);
         end
         begin
            // reset state and bring-up
            tick(3);
            lit("rst", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
            rst_n = 1'b1;
            tick(7);  lit("up7", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
            tick(1);  lit("up8", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
            tick(31); lit("up39", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
            tick(1);  lit("up40", 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
            tick(1);  lit("up41", 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);

            // 1000M -> 100M with idle TX
            phy_speed = 2'b01;
            tick(15); lit("c15", 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
            tick(1);  lit("c16", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
            tick(1);  lit("c17", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
            tick(7);  lit("c24", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
            tick(1);  lit("c25", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
            tick(31); lit("c56", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
            tick(1);  lit("c57", 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);

            // toggling every 10 cycles never debounces
            saw = 1'b0;
            for (int i = 0; i < 10; i++) begin
               phy_speed = (i % 2 == 0) ? 2'b10 : 2'b01;
               for (int j = 0; j < 10; j++) begin
                  tick(1);
                  if (tx_hold) saw = 1'b1;
               end
            end
            chk1("toggle_no_hold", saw, 1'b0);
            chk2("toggle_speed", speed, 2'b01);

            // invalid code ignored
            phy_speed = 2'b11;
            saw = 1'b0;
            for (int j = 0; j < 100; j++) begin
               tick(1);
               if (tx_hold) saw = 1'b1;
            end
            chk1("invalid_no_hold", saw, 1'b0);
            chk2("invalid_speed", speed, 2'b01);
            phy_speed = 2'b01;
            tick(2);

            // change to 10M with a 200-cycle drain
            tx_busy = 1'b1;
            phy_speed = 2'b00;
            tick(16);  lit("b16", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
            tick(200); lit("b216", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
            tx_busy = 1'b0;
            tick(1);   lit("b217", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
            tick(40);  lit("b257", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);

            // busy stuck: forced drain, then reset mid-settle
            tx_busy = 1'b1;
            phy_speed = 2'b01;
            tick(16);   lit("t16", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
            tick(4095); lit("t4111", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
            tick(1);    lit("t4112", 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
            tx_busy = 1'b0;
            tick(1);    lit("t4113", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
            tick(15);   lit("t4128", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
            #1 rst_n = 1'b0;
            #1 lit("abort", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
            tick(2);
            rst_n = 1'b1;
            tick(40); lit("re40", 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
            tick(3);
         end
      join_any
      disable fork;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
